// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB round-robin arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef logic gnt_t;

  // Pointer starts on requester 1 so requester 0 wins the first tie.
  localparam gnt_t PTR_RST = 1'b1;

endpackage

// File: rtl/apb_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant decision; the caller owns the last-grant pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_c
);

  always_comb begin
    gnt_c = 1'b0;
    if (req == 2'b11) begin
      gnt_c = ~last;
    end else if (req[1]) begin
      gnt_c = 1'b1;
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Serialises two APB requesters onto one completer with round-robin fairness,
// regenerating a clean SETUP/ACCESS sequence on the shared side.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned G_REGWIDTH   = 32,
  parameter int unsigned G_ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s0_apb_psel,
  input  logic                    s0_apb_penable,
  input  logic                    s0_apb_pwrite,
  input  logic [2:0]              s0_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0] s0_apb_paddr,
  input  logic [G_REGWIDTH-1:0]   s0_apb_pwdata,
  output logic                    s0_apb_pready,
  output logic                    s0_apb_pslverr,
  output logic [G_REGWIDTH-1:0]   s0_apb_prdata,
  input  logic                    s1_apb_psel,
  input  logic                    s1_apb_penable,
  input  logic                    s1_apb_pwrite,
  input  logic [2:0]              s1_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0] s1_apb_paddr,
  input  logic [G_REGWIDTH-1:0]   s1_apb_pwdata,
  output logic                    s1_apb_pready,
  output logic                    s1_apb_pslverr,
  output logic [G_REGWIDTH-1:0]   s1_apb_prdata,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [G_REGWIDTH-1:0]   m_apb_pwdata,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr,
  input  logic [G_REGWIDTH-1:0]   m_apb_prdata
);

  state_e state, state_n;
  gnt_t   last, last_n;
  gnt_t   cur, cur_n;
  gnt_t   gnt_c;
  logic [1:0] req_c;

  logic                    m_psel_n, m_penable_n, m_pwrite_n;
  logic [2:0]              m_pprot_n;
  logic [G_ADDR_WIDTH-1:0] m_paddr_n;
  logic [G_REGWIDTH-1:0]   m_pwdata_n;
  logic                    s0_pready_n, s0_pslverr_n, s1_pready_n, s1_pslverr_n;
  logic [G_REGWIDTH-1:0]   s0_prdata_n, s1_prdata_n, rsp_rdata_c;

  // penable plays no part in arbitration: both requester phases qualify.
  logic unused_penable;
  assign unused_penable = s0_apb_penable ^ s1_apb_penable;

  assign req_c = {s1_apb_psel, s0_apb_psel};

  rr_arb2 u_rr_arb2 (
    .req   (req_c),
    .last  (last),
    .gnt_c (gnt_c)
  );

  assign rsp_rdata_c = m_apb_pwrite ? '0 : m_apb_prdata;

  always_comb begin
    state_n      = state;
    last_n       = last;
    cur_n        = cur;
    m_psel_n     = m_apb_psel;
    m_penable_n  = m_apb_penable;
    m_pwrite_n   = m_apb_pwrite;
    m_pprot_n    = m_apb_pprot;
    m_paddr_n    = m_apb_paddr;
    m_pwdata_n   = m_apb_pwdata;
    s0_pready_n  = 1'b0;
    s0_pslverr_n = 1'b0;
    s0_prdata_n  = '0;
    s1_pready_n  = 1'b0;
    s1_pslverr_n = 1'b0;
    s1_prdata_n  = '0;
    case (state)
      IDLE: begin
        if (|req_c) begin
          state_n     = SETUP;
          cur_n       = gnt_c;
          m_psel_n    = 1'b1;
          m_penable_n = 1'b0;
          if (gnt_c) begin
            m_pwrite_n = s1_apb_pwrite;
            m_pprot_n  = s1_apb_pprot;
            m_paddr_n  = s1_apb_paddr;
            m_pwdata_n = s1_apb_pwdata;
          end else begin
            m_pwrite_n = s0_apb_pwrite;
            m_pprot_n  = s0_apb_pprot;
            m_paddr_n  = s0_apb_paddr;
            m_pwdata_n = s0_apb_pwdata;
          end
        end
      end
      SETUP: begin
        state_n     = ACCESS;
        m_penable_n = 1'b1;
      end
      ACCESS: begin
        if (m_apb_pready) begin
          state_n     = RESP;
          last_n      = cur;
          m_psel_n    = 1'b0;
          m_penable_n = 1'b0;
          if (cur) begin
            s1_pready_n  = 1'b1;
            s1_pslverr_n = m_apb_pslverr;
            s1_prdata_n  = rsp_rdata_c;
          end else begin
            s0_pready_n  = 1'b1;
            s0_pslverr_n = m_apb_pslverr;
            s0_prdata_n  = rsp_rdata_c;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last           <= PTR_RST;
      cur            <= 1'b0;
      m_apb_psel     <= 1'b0;
      m_apb_penable  <= 1'b0;
      m_apb_pwrite   <= 1'b0;
      m_apb_pprot    <= '0;
      m_apb_paddr    <= '0;
      m_apb_pwdata   <= '0;
      s0_apb_pready  <= 1'b0;
      s0_apb_pslverr <= 1'b0;
      s0_apb_prdata  <= '0;
      s1_apb_pready  <= 1'b0;
      s1_apb_pslverr <= 1'b0;
      s1_apb_prdata  <= '0;
    end else begin
      state          <= state_n;
      last           <= last_n;
      cur            <= cur_n;
      m_apb_psel     <= m_psel_n;
      m_apb_penable  <= m_penable_n;
      m_apb_pwrite   <= m_pwrite_n;
      m_apb_pprot    <= m_pprot_n;
      m_apb_paddr    <= m_paddr_n;
      m_apb_pwdata   <= m_pwdata_n;
      s0_apb_pready  <= s0_pready_n;
      s0_apb_pslverr <= s0_pslverr_n;
      s0_apb_prdata  <= s0_prdata_n;
      s1_apb_pready  <= s1_pready_n;
      s1_apb_pslverr <= s1_pslverr_n;
      s1_apb_prdata  <= s1_prdata_n;
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: requester/completer BFMs, a
// transaction-schedule model checked every cycle, and directed scenarios.
module tb_apb_rr_arbiter;

  typedef struct packed {
    logic        wr;
    logic [2:0]  prot;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        sel_i   [2];
  logic        en_i    [2];
  logic        wr_i    [2];
  logic [2:0]  prot_i  [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];

  logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
  logic [31:0] s0_prdata, s1_prdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [2:0]  m_pprot;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pready_i, m_pslverr_i;
  logic [31:0] m_prdata_i;

  apb_rr_arbiter #(.G_REGWIDTH(32), .G_ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_apb_psel    (sel_i[0]),
    .s0_apb_penable (en_i[0]),
    .s0_apb_pwrite  (wr_i[0]),
    .s0_apb_pprot   (prot_i[0]),
    .s0_apb_paddr   (addr_i[0]),
    .s0_apb_pwdata  (wdata_i[0]),
    .s0_apb_pready  (s0_pready),
    .s0_apb_pslverr (s0_pslverr),
    .s0_apb_prdata  (s0_prdata),
    .s1_apb_psel    (sel_i[1]),
    .s1_apb_penable (en_i[1]),
    .s1_apb_pwrite  (wr_i[1]),
    .s1_apb_pprot   (prot_i[1]),
    .s1_apb_paddr   (addr_i[1]),
    .s1_apb_pwdata  (wdata_i[1]),
    .s1_apb_pready  (s1_pready),
    .s1_apb_pslverr (s1_pslverr),
    .s1_apb_prdata  (s1_prdata),
    .m_apb_psel     (m_psel),
    .m_apb_penable  (m_penable),
    .m_apb_pwrite   (m_pwrite),
    .m_apb_pprot    (m_pprot),
    .m_apb_paddr    (m_paddr),
    .m_apb_pwdata   (m_pwdata),
    .m_apb_pready   (m_pready_i),
    .m_apb_pslverr  (m_pslverr_i),
    .m_apb_prdata   (m_prdata_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // requester queues and phase (0 idle, 1 setup, 2 access)
  txn_t tq [2][16];
  int   qh [2];
  int   qt [2];
  int   phase [2];
  logic prev_rdy [2];

  // completer behaviour
  int          wait_cfg = 0;
  logic        err_cfg = 1'b0;
  logic [31:0] rd_cfg = 32'h0;
  int          acc_cnt = 0;

  // transaction-schedule model
  logic        m_busy;
  int          m_g, m_last, m_t, m_tresp;
  logic        m_wr, m_err;
  logic [2:0]  m_prot;
  logic [31:0] m_addr, m_wdata, m_rd;

  // observation log
  int          served [$];
  int          npulse [2];
  int          rdy_cyc [2];
  int          start_cyc [2];
  logic [31:0] cap_rdata [2];
  logic        cap_err [2];
  int          psel_rise, pen_rise;
  logic [31:0] cap_addr, cap_wdata;
  logic        prev_mpsel, prev_mpen;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic all_idle();
    return (qh[0] == qt[0]) && (qh[1] == qt[1]) && (phase[0] == 0) && (phase[1] == 0)
           && (!m_busy || cyc > m_tresp);
  endfunction

  task automatic push(input int k, input logic w, input logic [2:0] p,
                      input logic [31:0] a, input logic [31:0] d);
    tq[k][qt[k]] = '{wr: w, prot: p, addr: a, data: d};
    qt[k]++;
  endtask

  task automatic clr_log();
    served.delete();
    for (int k = 0; k < 2; k++) begin
      npulse[k] = 0; rdy_cyc[k] = -1; start_cyc[k] = -1;
      cap_rdata[k] = 32'h0; cap_err[k] = 1'b0;
    end
    psel_rise = -1; pen_rise = -1;
  endtask

  // Model: outputs for cycle cyc follow from the grant made on the inputs of cycle cyc-1.
  task automatic model_step();
    logic e_psel, e_pen, e_rsp;
    logic [31:0] e_rd;
    if (m_busy && (cyc - 1) > m_tresp) m_busy = 1'b0;
    if (!m_busy && (sel_i[0] || sel_i[1])) begin
      if (sel_i[0] && sel_i[1]) m_g = (m_last == 0) ? 1 : 0;
      else                      m_g = sel_i[1] ? 1 : 0;
      m_t     = cyc - 1;
      m_tresp = m_t + 3 + wait_cfg;
      m_wr    = wr_i[m_g];
      m_prot  = prot_i[m_g];
      m_addr  = addr_i[m_g];
      m_wdata = wdata_i[m_g];
      m_rd    = rd_cfg;
      m_err   = err_cfg;
      m_busy  = 1'b1;
    end
    e_psel = m_busy && (cyc > m_t) && (cyc < m_tresp);
    e_pen  = m_busy && (cyc > m_t + 1) && (cyc < m_tresp);
    e_rsp  = m_busy && (cyc == m_tresp);
    if (e_rsp) m_last = m_g;
    e_rd = m_wr ? 32'h0 : m_rd;
    chk("m_psel",    64'(m_psel),    64'(e_psel));
    chk("m_penable", 64'(m_penable), 64'(e_pen));
    chk("m_pwrite",  64'(m_pwrite),  64'(m_wr));
    chk("m_pprot",   64'(m_pprot),   64'(m_prot));
    chk("m_paddr",   64'(m_paddr),   64'(m_addr));
    chk("m_pwdata",  64'(m_pwdata),  64'(m_wdata));
    chk("s0_pready",  64'(s0_pready),  64'(e_rsp && m_g == 0));
    chk("s0_pslverr", 64'(s0_pslverr), 64'(e_rsp && m_g == 0 && m_err));
    chk("s0_prdata",  64'(s0_prdata),  64'((e_rsp && m_g == 0) ? e_rd : 32'h0));
    chk("s1_pready",  64'(s1_pready),  64'(e_rsp && m_g == 1));
    chk("s1_pslverr", 64'(s1_pslverr), 64'(e_rsp && m_g == 1 && m_err));
    chk("s1_prdata",  64'(s1_prdata),  64'((e_rsp && m_g == 1) ? e_rd : 32'h0));
  endtask

  task automatic step();
    txn_t t;
    logic rdy [2];
    @(posedge clk); #1;
    cyc++;
    model_step();
    rdy[0] = s0_pready;
    rdy[1] = s1_pready;
    if (s0_pready) begin
      npulse[0]++; rdy_cyc[0] = cyc; cap_rdata[0] = s0_prdata; cap_err[0] = s0_pslverr;
      served.push_back(0);
    end
    if (s1_pready) begin
      npulse[1]++; rdy_cyc[1] = cyc; cap_rdata[1] = s1_prdata; cap_err[1] = s1_pslverr;
      served.push_back(1);
    end
    if (m_psel && !prev_mpsel) begin
      psel_rise = cyc; cap_addr = m_paddr; cap_wdata = m_pwdata;
    end
    if (m_penable && !prev_mpen) pen_rise = cyc;
    prev_mpsel = m_psel;
    prev_mpen  = m_penable;
    for (int k = 0; k < 2; k++) begin
      if (phase[k] == 2 && prev_rdy[k]) begin
        qh[k]++;
        phase[k] = 0;
      end else if (phase[k] == 1) begin
        phase[k] = 2;
      end
      if (phase[k] == 0 && qh[k] != qt[k]) begin
        phase[k] = 1;
        start_cyc[k] = cyc;
      end
      sel_i[k] = (phase[k] != 0);
      en_i[k]  = (phase[k] == 2);
      if (phase[k] != 0) begin
        t = tq[k][qh[k]];
        wr_i[k] = t.wr; prot_i[k] = t.prot; addr_i[k] = t.addr; wdata_i[k] = t.data;
      end else begin
        wr_i[k] = 1'b0; prot_i[k] = 3'b0; addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
      end
      prev_rdy[k] = rdy[k];
    end
    if (m_psel && m_penable) begin
      m_pready_i = (acc_cnt == wait_cfg);
      acc_cnt    = m_pready_i ? 0 : acc_cnt + 1;
    end else begin
      m_pready_i = 1'b0;
      acc_cnt    = 0;
    end
    m_pslverr_i = m_pready_i & err_cfg;
    m_prdata_i  = rd_cfg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sel_i[k] = 1'b0; en_i[k] = 1'b0; wr_i[k] = 1'b0; prot_i[k] = 3'b0;
      addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
      qh[k] = 0; qt[k] = 0; phase[k] = 0; prev_rdy[k] = 1'b0;
    end
    m_pready_i = 1'b0; m_pslverr_i = 1'b0; m_prdata_i = 32'h0; acc_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    cyc += 2;
    chk("rst_m_psel",    64'(m_psel),    64'(0));
    chk("rst_m_penable", 64'(m_penable), 64'(0));
    chk("rst_m_paddr",   64'(m_paddr),   64'(0));
    chk("rst_s0_pready", 64'(s0_pready), 64'(0));
    chk("rst_s1_pready", 64'(s1_pready), 64'(0));
    rst = 1'b0;
    m_busy = 1'b0; m_last = 1; m_g = 0; m_t = 0; m_tresp = 0;
    m_wr = 1'b0; m_err = 1'b0; m_prot = 3'b0; m_addr = 32'h0; m_wdata = 32'h0; m_rd = 32'h0;
    prev_mpsel = 1'b0; prev_mpen = 1'b0;
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && n < budget);
    n_chk++;
    if (!all_idle()) begin
      n_fail++;
      $display("FAIL timeout_%s cyc=%0d act=busy exp=idle", tag, cyc);
    end
    step();
    step();
  endtask

  initial begin
    int v;
    do_reset();

    // single write, zero completer wait states
    clr_log();
    wait_cfg = 0; err_cfg = 1'b0; rd_cfg = 32'hA5A5_0000;
    push(0, 1'b1, 3'b001, 32'h10, 32'hDEADBEEF);
    run_idle(50, "wr");
    chk("wr_psel_lat",  64'(psel_rise - start_cyc[0]), 64'(1));
    chk("wr_pen_lat",   64'(pen_rise - start_cyc[0]),  64'(2));
    chk("wr_rdy_lat",   64'(rdy_cyc[0] - start_cyc[0]), 64'(3));
    chk("wr_paddr",     64'(cap_addr),  64'(32'h10));
    chk("wr_pwdata",    64'(cap_wdata), 64'(32'hDEADBEEF));
    chk("wr_s0_pulses", 64'(npulse[0]), 64'(1));
    chk("wr_s1_pulses", 64'(npulse[1]), 64'(0));

    // read with three completer wait states
    clr_log();
    wait_cfg = 3; rd_cfg = 32'h12345678;
    push(1, 1'b0, 3'b010, 32'h20, 32'h0);
    run_idle(50, "rd");
    chk("rd_rdy_lat",   64'(rdy_cyc[1] - start_cyc[1]), 64'(6));
    chk("rd_prdata",    64'(cap_rdata[1]), 64'(32'h12345678));
    chk("rd_s1_pulses", 64'(npulse[1]), 64'(1));
    chk("rd_s0_pulses", 64'(npulse[0]), 64'(0));

    // simultaneous requests right after reset, five back-to-back pairs
    do_reset();
    clr_log();
    wait_cfg = 0; rd_cfg = 32'hCAFE_0001;
    for (int i = 0; i < 5; i++) begin
      push(0, 1'b1, 3'(i), 32'h100 + 32'(i), 32'h1000 + 32'(i));
      push(1, 1'b0, 3'(i + 2), 32'h200 + 32'(i), 32'h0);
    end
    run_idle(200, "rr");
    chk("rr_count", 64'(served.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      v = (i < served.size()) ? served[i] : 9;
      chk($sformatf("rr_order%0d", i), 64'(v), 64'(i % 2));
    end

    // error propagation, then a clean transfer
    clr_log();
    wait_cfg = 1; err_cfg = 1'b1;
    push(0, 1'b1, 3'b000, 32'h30, 32'h0BAD_F00D);
    run_idle(50, "err");
    chk("err_pslverr", 64'(cap_err[0]), 64'(1));
    chk("err_pulses",  64'(npulse[0]),  64'(1));
    err_cfg = 1'b0;
    push(0, 1'b1, 3'b000, 32'h34, 32'h0000_1111);
    run_idle(50, "err2");
    chk("err2_pslverr", 64'(cap_err[0]), 64'(0));
    chk("err2_pulses",  64'(npulse[0]),  64'(2));

    // reset while the completer stalls in ACCESS; pointer now points at s0
    clr_log();
    wait_cfg = 0;
    push(0, 1'b1, 3'b000, 32'h40, 32'h4444_4444);
    run_idle(50, "pre");
    clr_log();
    wait_cfg = 20;
    push(1, 1'b1, 3'b011, 32'h44, 32'h5555_5555);
    for (int i = 0; i < 4; i++) step();
    chk("mid_in_access", 64'(m_penable), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_psel",    64'(m_psel),    64'(0));
    chk("arst_m_penable", 64'(m_penable), 64'(0));
    chk("arst_s0_pready", 64'(s0_pready), 64'(0));
    chk("arst_s1_pready", 64'(s1_pready), 64'(0));
    do_reset();
    chk("abort_s1_pulses", 64'(npulse[1]), 64'(0));
    clr_log();
    wait_cfg = 0;
    push(0, 1'b1, 3'b000, 32'h50, 32'h6666_6666);
    push(1, 1'b1, 3'b000, 32'h54, 32'h7777_7777);
    run_idle(100, "post");
    chk("post_count",  64'(served.size()), 64'(2));
    v = (served.size() > 0) ? served[0] : 9;
    chk("post_first",  64'(v), 64'(0));
    v = (served.size() > 1) ? served[1] : 9;
    chk("post_second", 64'(v), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
